// File: rtl/led_sequencer.sv
// Front-panel pattern sequencer: debounces two switches into mode-advance and
// pause presses, then steps an 8-bit count/rotate/bounce pattern on a prescaled tick.
module led_sequencer #(
    parameter int TICK_DIV        = 30000000,
    parameter int DEBOUNCE_CYCLES = 600000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw1,
    input  logic       sw2,
    output logic [7:0] pattern,
    output logic [1:0] mode,
    output logic       led1,
    output logic       led2
);

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]     raw_s;
    logic [1:0]     sync_a_r;
    logic [1:0]     sync_b_r;
    logic [1:0]     db_r;
    logic [1:0]     db_d_r;
    logic [1:0]     press_r;
    logic [DBW-1:0] db_cnt_r [2];

    // index 0 is the mode-advance switch, index 1 the pause switch
    assign raw_s = {sw2, sw1};

    // Two-flop synchroniser, per-switch debounce counter and rising-edge press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a_r <= 2'b00;
            sync_b_r <= 2'b00;
            db_r     <= 2'b00;
            db_d_r   <= 2'b00;
            press_r  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= {DBW{1'b0}};
            end
        end else begin
            sync_a_r <= raw_s;
            sync_b_r <= sync_a_r;
            db_d_r   <= db_r;
            press_r  <= db_r & ~db_d_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_b_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= {DBW{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_r[i]     <= sync_b_r[i];
                    db_cnt_r[i] <= {DBW{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DBW'(1'b1);
                end
            end
        end
    end

    mode_e         mode_r;
    mode_e         mode_next_s;
    logic [7:0]    pattern_r;
    logic [7:0]    pattern_next_s;
    logic          dir_r;          // 0 = moving left, 1 = moving right
    logic          dir_next_s;
    logic          paused_r;
    logic          paused_next_s;
    logic          led2_r;
    logic          led2_next_s;
    logic [TW-1:0] tick_cnt_r;
    logic [TW-1:0] tick_cnt_next_s;
    logic          tick_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r     <= MODE_STOP;
            pattern_r  <= 8'h00;
            dir_r      <= 1'b0;
            paused_r   <= 1'b0;
            led2_r     <= 1'b0;
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            mode_r     <= mode_next_s;
            pattern_r  <= pattern_next_s;
            dir_r      <= dir_next_s;
            paused_r   <= paused_next_s;
            led2_r     <= led2_next_s;
            tick_cnt_r <= tick_cnt_next_s;
        end
    end

    // Next-state logic: mode entry loads take priority over a coincident tick
    always_comb begin
        mode_next_s     = mode_r;
        pattern_next_s  = pattern_r;
        dir_next_s      = dir_r;
        paused_next_s   = press_r[1] ? ~paused_r : paused_r;
        led2_next_s     = tick_s ? ~led2_r : led2_r;
        tick_cnt_next_s = tick_s ? {TW{1'b0}} : tick_cnt_r + TW'(1'b1);

        if (press_r[0]) begin
            tick_cnt_next_s = {TW{1'b0}};
            case (mode_r)
                MODE_STOP:   mode_next_s = MODE_COUNT;
                MODE_COUNT:  mode_next_s = MODE_SHIFT;
                MODE_SHIFT:  mode_next_s = MODE_BOUNCE;
                MODE_BOUNCE: mode_next_s = MODE_STOP;
                default:     mode_next_s = MODE_STOP;
            endcase
            case (mode_next_s)
                MODE_STOP:   pattern_next_s = 8'h00;
                MODE_COUNT:  pattern_next_s = 8'h00;
                MODE_SHIFT:  pattern_next_s = 8'h01;
                MODE_BOUNCE: begin
                    pattern_next_s = 8'h01;
                    dir_next_s     = 1'b0;
                end
                default:     pattern_next_s = 8'h00;
            endcase
        end else if (tick_s && !paused_r) begin
            case (mode_r)
                MODE_STOP:   pattern_next_s = pattern_r;
                MODE_COUNT:  pattern_next_s = pattern_r + 8'd1;
                MODE_SHIFT:  pattern_next_s = {pattern_r[6:0], pattern_r[7]};
                MODE_BOUNCE: begin
                    if (!dir_r) begin
                        pattern_next_s = {pattern_r[6:0], 1'b0};
                        dir_next_s     = (pattern_next_s == 8'h80);
                    end else begin
                        pattern_next_s = {1'b0, pattern_r[7:1]};
                        dir_next_s     = (pattern_next_s != 8'h01);
                    end
                end
                default:     pattern_next_s = pattern_r;
            endcase
        end else begin
            pattern_next_s = pattern_r;
        end
    end

    assign pattern = pattern_r;
    assign mode    = mode_r;
    assign led1    = paused_r;
    assign led2    = led2_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4 and DEBOUNCE_CYCLES=3;
// expected values are hand-derived cycle counts and pattern tables.
module tb_led_sequencer;

    localparam int TICK_DIV = 4;
    localparam int DB_CYC   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw1;
    logic       sw2;
    logic [7:0] pattern;
    logic [1:0] mode;
    logic       led1;
    logic       led2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] bseq [24] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                              8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    led_sequencer #(
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE_CYCLES(DB_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw1(sw1),
        .sw2(sw2),
        .pattern(pattern),
        .mode(mode),
        .led1(led1),
        .led2(led2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sw1 = 1'b0;
        sw2 = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Raise the selected switches; the seventh edge is the one where mode/pause updates
    task automatic press(input logic [1:0] which);
        sw1 = which[0];
        sw2 = which[1];
        step(7);
        sw1 = 1'b0;
        sw2 = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_p;
        int toggles;
        logic last_led2;

        // Reset with both switches held, then both presses land together
        reset = 1'b1;
        sw1 = 1'b1;
        sw2 = 1'b1;
        step(2);
        check_val("rst_mode", 32'(mode), 32'd0);
        check_val("rst_pattern", 32'(pattern), 32'h00);
        check_val("rst_led1", 32'(led1), 32'd0);
        check_val("rst_led2", 32'(led2), 32'd0);
        reset = 1'b0;
        step(6);
        check_val("press_latency_early", 32'(mode), 32'd0);
        step(1);
        check_val("press_latency_mode", 32'(mode), 32'd1);
        check_val("press_latency_led1", 32'(led1), 32'd1);
        check_val("press_latency_pattern", 32'(pattern), 32'h00);
        sw1 = 1'b0;
        sw2 = 1'b0;

        // Debounce: short glitch rejected, long press accepted exactly once
        do_reset();
        sw1 = 1'b1;
        step(2);
        sw1 = 1'b0;
        step(10);
        check_val("glitch_mode", 32'(mode), 32'd0);
        sw1 = 1'b1;
        step(6);
        check_val("db_mode_early", 32'(mode), 32'd0);
        step(1);
        check_val("db_mode", 32'(mode), 32'd1);
        check_val("db_entry_pattern", 32'(pattern), 32'h00);
        step(1);
        sw1 = 1'b0;
        step(10);
        check_val("db_release_mode", 32'(mode), 32'd1);
        check_val("db_count_pattern", 32'(pattern), 32'h02);

        // COUNT: one step every 4 cycles, 8-bit wrap, heartbeat toggling
        do_reset();
        press(2'b01);
        check_val("count_mode", 32'(mode), 32'd1);
        check_val("count_entry", 32'(pattern), 32'h00);
        check_val("count_led2_entry", 32'(led2), 32'd1);
        for (int k = 1; k <= 1028; k++) begin
            step(1);
            exp_p = 8'(k / 4);
            check_val("count_pattern", 32'(pattern), 32'(exp_p));
            check_val("count_led2", 32'(led2), 32'(1 ^ ((k / 4) & 1)));
        end

        // BOUNCE: sweep both directions, then reset at 0x20 moving right
        do_reset();
        press(2'b01);
        step(6);
        press(2'b01);
        step(6);
        press(2'b01);
        check_val("bounce_mode", 32'(mode), 32'd3);
        check_val("bounce_entry", 32'(pattern), 32'(bseq[0]));
        for (int k = 1; k < 24; k++) begin
            step(4);
            check_val("bounce_pattern", 32'(pattern), 32'(bseq[k]));
        end
        reset = 1'b1;
        step(1);
        check_val("bounce_rst_pattern", 32'(pattern), 32'h00);
        check_val("bounce_rst_mode", 32'(mode), 32'd0);
        reset = 1'b0;

        // Pause in SHIFT at 0x04, then simultaneous sw1+sw2
        do_reset();
        press(2'b01);
        step(6);
        press(2'b01);
        check_val("shift_mode", 32'(mode), 32'd2);
        check_val("shift_entry", 32'(pattern), 32'h01);
        step(2);
        press(2'b10);
        check_val("pause_led1", 32'(led1), 32'd1);
        check_val("pause_pattern", 32'(pattern), 32'h04);
        toggles = 0;
        last_led2 = led2;
        for (int k = 0; k < 40; k++) begin
            step(1);
            check_val("pause_frozen", 32'(pattern), 32'h04);
            if (led2 !== last_led2) toggles++;
            last_led2 = led2;
        end
        check_val("pause_led2_toggles", 32'(toggles), 32'd10);
        press(2'b11);
        check_val("simul_mode", 32'(mode), 32'd3);
        check_val("simul_pattern", 32'(pattern), 32'h01);
        check_val("simul_led1", 32'(led1), 32'd0);

        // Mode wrap: four presses from STOP
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(2'b01);
            check_val("wrap_mode", 32'(mode), 32'((i + 1) % 4));
            step(6);
        end
        check_val("wrap_pattern", 32'(pattern), 32'h00);
        step(12);
        check_val("wrap_pattern_hold", 32'(pattern), 32'h00);
        check_val("wrap_mode_hold", 32'(mode), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Front-panel pattern controller sitting between the board switches and the PMOD1 header/LEDs in the 60 MHz PLL domain. Debounces the two switches, turns presses into mode-advance and pause commands, and sequences an 8-bit output pattern (count, rotate, bounce) at a programmable tick rate. Replaces free-running counter bits on the PMOD pins with a controlled, user-selectable sequence.

## Interface
- TICK_DIV, 30000000, clk cycles per pattern step (≥2); 30000000 = 0.5 s at 60 MHz
- DEBOUNCE_CYCLES, 600000, consecutive stable cycles required to accept a switch change (≥1); 10 ms at 60 MHz
- clk  input  1  PLL clock (60 MHz); all logic rising-edge
- reset  input  1  synchronous, active-high; one clock; sampled on rising edge of clk
- sw1  input  1  raw switch, active-high (pressed = 1), asynchronous; press advances mode
- sw2  input  1  raw switch, active-high, asynchronous; press toggles pause
- pattern  output  8  PMOD1 drive; bit0→pmod1_1 … bit7→pmod1_10 (top-level mapping)
- mode  output  2  current mode: 0 STOP, 1 COUNT, 2 SHIFT, 3 BOUNCE
- led1  output  1  1 while paused
- led2  output  1  heartbeat; toggles on every tick

## Operation
- Synchroniser: each switch through 2 flops (reset 0).
- Debouncer per switch: stable state `db`, counter. If sync output ≠ db, counter increments; when it would reach DEBOUNCE_CYCLES, db takes sync value and counter clears. Any cycle sync == db clears counter. Glitches shorter than DEBOUNCE_CYCLES never change db.
- Press pulse: registered one-cycle pulse on db 0→1. Releases produce nothing.
- Prescaler: counts 0..TICK_DIV-1; tick asserted on the cycle it equals TICK_DIV-1, then wraps to 0. Cleared on mode change and on reset. Runs while paused.
- Mode FSM: sw1 press → mode+1 mod 4 (BOUNCE→STOP). Entry actions, applied on the transition edge and overriding any same-cycle tick:
  - STOP: pattern←0x00, held.
  - COUNT: pattern←0x00.
  - SHIFT: pattern←0x01.
  - BOUNCE: pattern←0x01, dir←left.
- sw2 press toggles `paused`. Paused: tick does not update pattern (led2 still toggles).
- On tick, not paused, no mode change:
  - COUNT: pattern+1, 8-bit wrap 0xFF→0x00.
  - SHIFT: rotate left, 0x80→0x01.
  - BOUNCE: dir left: shift left; when result is 0x80, dir←right. Dir right: shift right; at 0x01, dir←left. Sequence 01,02,…,80,40,…,01,02 (no end value repeated).
  - STOP: no change.
- Simultaneous sw1 and sw2 presses in one cycle: both applied (mode advances and pause toggles).
- Reset (any time, incl. mid-debounce or mid-bounce): mode 0, pattern 0x00, paused 0, led1 0, led2 0, dir left, all sync/db/counters 0, no pulses.

## Timing
- All outputs registered; no combinational input→output path.
- Raw switch edge to press pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle pulse register; mode/paused update on the edge after the pulse.
- Tick period exactly TICK_DIV cycles; first tick after reset or mode entry occurs TICK_DIV cycles after that edge.
- pattern and led2 update on the same edge as the tick.
- mode output changes on the same edge as the entry load of pattern.

## Test plan
(TICK_DIV=4, DEBOUNCE_CYCLES=3)
- Reset: hold reset 2 cycles with sw1=sw2=1 → mode=0, pattern=0x00, led1=0, led2=0; release, switches held → one press pulse after 2+3+1 cycles, mode=1.
- Debounce: sw1 pulsed high 2 cycles, low 10 → mode unchanged; high 8 cycles → mode advances exactly once; release → no change.
- COUNT: enter mode 1, run 1028 cycles → pattern steps 0x01,0x02,… every 4 cycles, 0xFF→0x00 wrap seen, led2 toggles every 4 cycles.
- BOUNCE: enter mode 3 → pattern 01,02,04,…,80,40,…,01,02 at 4-cycle spacing; assert reset at 0x20 going right → pattern=0x00, mode=0 next edge.
- Pause and simultaneity: in SHIFT at 0x04, press sw2 → led1=1, pattern frozen at 0x04 for 40 cycles while led2 keeps toggling; press sw1 and sw2 in same cycle → mode=3, pattern=0x01, led1=0.
- Mode wrap: four sw1 presses from STOP → modes 1,2,3,0; final pattern=0x00 and stays 0x00 across ticks.
